// File: rtl/servo_pwm_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator:
// counter width and the position code to pulse width mapping.
package servo_pwm_pkg;

   localparam int CONT_W = 32;

   // Width step between adjacent position codes (integer division).
   function automatic logic [CONT_W-1:0] calc_delta(input int lmin, input int lmax,
                                                    input int bits_pos);
      return CONT_W'((lmax - lmin) / ((1 << bits_pos) - 1));
   endfunction

   // Linear map of a position code to a width in clock cycles. The top code is
   // pinned to lmax so the truncation remainder never leaves a gap at full scale.
   function automatic logic [CONT_W-1:0] pos_para_largura(input logic [CONT_W-1:0] pos,
                                                          input int lmin, input int lmax,
                                                          input int bits_pos);
      logic [CONT_W-1:0] topo;
      topo = CONT_W'((1 << bits_pos) - 1);
      if (pos >= topo) begin
         return CONT_W'(lmax);
      end
      return CONT_W'(lmin) + pos * calc_delta(lmin, lmax, bits_pos);
   endfunction

endpackage

// File: rtl/servo_pwm_multicanal_if.sv
// Write bus from the position-control FSM: one strobe, channel index and
// target position. No backpressure, a write may arrive every cycle.
interface servo_pwm_multicanal_if #(
   parameter int BITS_POS = 3
) ();

   logic                wr_en;
   logic [3:0]          wr_canal;
   logic [BITS_POS-1:0] wr_pos;

   modport master (output wr_en, output wr_canal, output wr_pos);
   modport slave  (input  wr_en, input  wr_canal, input  wr_pos);

endinterface

// File: rtl/servo_pwm_canal.sv
// One servo channel: target and current width, per-period ramp toward the
// target, and the registered PWM / moving flags.
module servo_pwm_canal
   import servo_pwm_pkg::*;
#(
   parameter int BITS_POS    = 3,
   parameter int LARGURA_MIN = 35000,
   parameter int LARGURA_MAX = 110000,
   parameter int PASSO_RAMPA = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic                fronteira,
   input  logic                wr_sel,
   input  logic [BITS_POS-1:0] wr_pos,
   input  logic [CONT_W-1:0]   contagem_k,
   output logic                pwm,
   output logic                em_movimento
);

   localparam logic [CONT_W-1:0] L_MIN = CONT_W'(LARGURA_MIN);
   localparam logic [CONT_W-1:0] PASSO = CONT_W'(PASSO_RAMPA);

   logic [CONT_W-1:0] alvo;
   logic [CONT_W-1:0] atual;
   logic [CONT_W-1:0] atual_nxt;

   // Next width one step toward the target; differences are taken in the
   // direction that cannot underflow, so the result stays between atual and alvo.
   always_comb begin
      atual_nxt = atual;
      if (PASSO == '0) begin
         atual_nxt = alvo;
      end else if (atual < alvo) begin
         atual_nxt = ((alvo - atual) > PASSO) ? (atual + PASSO) : alvo;
      end else if (atual > alvo) begin
         atual_nxt = ((atual - alvo) > PASSO) ? (atual - PASSO) : alvo;
      end
   end

   // Target captured on a write; width only moves on the period boundary so a
   // pulse in progress is never cut or stretched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alvo         <= L_MIN;
         atual        <= L_MIN;
         pwm          <= 1'b0;
         em_movimento <= 1'b0;
      end else begin
         if (wr_sel) begin
            alvo <= pos_para_largura(CONT_W'(wr_pos), LARGURA_MIN, LARGURA_MAX, BITS_POS);
         end
         if (fronteira) begin
            atual <= atual_nxt;
         end
         pwm          <= habilita & (contagem_k < atual);
         em_movimento <= (atual != alvo);
      end
   end

endmodule

// File: rtl/servo_pwm_multicanal.sv
// N-channel servo PWM generator: one shared period counter, write decode and
// end-of-period pulse; per-channel state lives in servo_pwm_canal.
// Optional build macro SERVO_PWM_DEFASAGEM_EN staggers each channel's counter
// phase by k*(CONF_PERIODO/N_CANAIS) so pulse starts do not coincide; the ramp
// boundary stays global either way.
module servo_pwm_multicanal
   import servo_pwm_pkg::*;
#(
   parameter int N_CANAIS     = 4,
   parameter int BITS_POS     = 3,
   parameter int CONF_PERIODO = 1000000,
   parameter int LARGURA_MIN  = 35000,
   parameter int LARGURA_MAX  = 110000,
   parameter int PASSO_RAMPA  = 1000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_CANAIS-1:0]  habilita,
   servo_pwm_multicanal_if.slave wr,
   output logic [N_CANAIS-1:0]  pwm,
   output logic [N_CANAIS-1:0]  em_movimento,
   output logic                 fim_periodo,
   output logic [CONT_W-1:0]    db_contagem
);

   localparam logic [CONT_W-1:0] ULTIMO = CONT_W'(CONF_PERIODO - 1);

   logic [CONT_W-1:0] contagem;
   logic [CONT_W-1:0] contagem_nxt;

   // Wrap the period counter after its last cycle.
   always_comb begin
      contagem_nxt = (contagem == ULTIMO) ? '0 : (contagem + CONT_W'(1));
   end

   // Period counter; fim_periodo is decoded from the next count so it is high
   // in exactly the cycle where contagem sits on its last value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contagem    <= '0;
         fim_periodo <= 1'b0;
      end else begin
         contagem    <= contagem_nxt;
         fim_periodo <= (contagem_nxt == ULTIMO);
      end
   end

   assign db_contagem = contagem;

   for (genvar k = 0; k < N_CANAIS; k++) begin : g_canal
      logic [CONT_W-1:0] contagem_k;
      logic              wr_sel;

      // Indices at or above N_CANAIS match no channel and fall through silently.
      assign wr_sel = wr.wr_en && (wr.wr_canal == 4'(k));

`ifdef SERVO_PWM_DEFASAGEM_EN
      localparam logic [CONT_W-1:0] DESLOC  = CONT_W'(k * (CONF_PERIODO / N_CANAIS));
      localparam logic [CONT_W-1:0] PERIODO = CONT_W'(CONF_PERIODO);
      logic [CONT_W-1:0] soma;
      assign soma       = contagem + DESLOC;
      assign contagem_k = (soma >= PERIODO) ? (soma - PERIODO) : soma;
`else
      assign contagem_k = contagem;
`endif

      servo_pwm_canal #(
         .BITS_POS    (BITS_POS),
         .LARGURA_MIN (LARGURA_MIN),
         .LARGURA_MAX (LARGURA_MAX),
         .PASSO_RAMPA (PASSO_RAMPA)
      ) u_canal (
         .clock        (clock),
         .reset        (reset),
         .habilita     (habilita[k]),
         .fronteira    (fim_periodo),
         .wr_sel       (wr_sel),
         .wr_pos       (wr.wr_pos),
         .contagem_k   (contagem_k),
         .pwm          (pwm[k]),
         .em_movimento (em_movimento[k])
      );
   end

endmodule

// File: doc/servo_pwm_multicanal.md
Name: servo_pwm_multicanal

Overview:
- N-channel servo PWM generator: one shared period counter drives several independent outputs.
- Per-channel 2^BITS_POS-level position is mapped linearly to a pulse width.
- Optional rate-limited ramp of the width, applied once per period, moves the servo toward its target.
- Sits between the position-control FSM and the servo pins; replaces single-channel fixed-table PWM generators.

Parameters:
- N_CANAIS, 4, number of PWM outputs (1..16)
- BITS_POS, 3, position code width; levels = 2^BITS_POS
- CONF_PERIODO, 1000000, PWM period in clock cycles (20 ms at 50 MHz)
- LARGURA_MIN, 35000, pulse width for position 0 (cycles)
- LARGURA_MAX, 110000, pulse width for top position (cycles); must be > LARGURA_MIN and <= CONF_PERIODO
- PASSO_RAMPA, 1000, max width change per period; 0 = jump directly to target

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- habilita  in  N_CANAIS  per-channel output enable
- wr_en  in  1  single-cycle write strobe for a target position
- wr_canal  in  4  channel index for the write
- wr_pos  in  BITS_POS  target position code
- pwm  out  N_CANAIS  registered PWM outputs
- em_movimento  out  N_CANAIS  1 while the channel's current width differs from its target
- fim_periodo  out  1  one-cycle pulse on the last cycle of each period
- db_contagem  out  32  period counter, for debug

Behaviour:
- Constant DELTA = (LARGURA_MAX-LARGURA_MIN)/(2^BITS_POS-1), integer division, computed at elaboration.
- Target width = LARGURA_MIN + wr_pos*DELTA, computed in 32 bits. The top code maps to exactly LARGURA_MAX; the truncation remainder is absorbed by the top code.
- Reset (async, reset=0):
  - contagem=0, pwm=0, em_movimento=0, fim_periodo=0.
  - alvo[k] and atual[k] = LARGURA_MIN for every channel.
  - Takes effect immediately, mid-period included. After release, counting restarts at 0 on the first clock edge.
- Counter: counts 0..CONF_PERIODO-1 and wraps to 0. fim_periodo=1 while contagem==CONF_PERIODO-1, registered so it coincides with that cycle.
- Write:
  - On wr_en=1 with wr_canal<N_CANAIS, alvo[wr_canal] is updated on that clock edge.
  - wr_canal>=N_CANAIS is ignored silently.
  - No backpressure; a write is accepted every cycle.
- Ramp, at the period boundary (contagem==CONF_PERIODO-1), per channel:
  - if atual<alvo: atual=min(atual+PASSO_RAMPA, alvo)
  - if atual>alvo: atual=max(atual-PASSO_RAMPA, alvo)
  - if PASSO_RAMPA=0: atual=alvo
  - Comparisons are done without overflow; atual never leaves [LARGURA_MIN, LARGURA_MAX].
- atual changes only at the boundary, so there are no glitched or partial pulses.
- Write on the boundary cycle: the ramp uses the old alvo; the new alvo takes effect at the following boundary.
- Output: pwm[k] <= habilita[k] & (contagem_k < atual[k]), registered, so there is one cycle of latency from the counter. contagem_k = contagem unless the optional feature is enabled.
  - Clearing habilita[k] forces pwm[k]=0 from the next edge.
  - The ramp continues while a channel is disabled.
- em_movimento[k] = registered (atual[k] != alvo[k]).

Optional Feature:
- Macro SERVO_PWM_DEFASAGEM_EN.
- Defined: channel k uses contagem_k = (contagem + k*(CONF_PERIODO/N_CANAIS)) mod CONF_PERIODO. Pulse starts are staggered to spread supply current. The ramp boundary stays global.
- Undefined: all channels use contagem, so every pulse rises in the same cycle.

Decomposition:
- Package servo_pwm_pkg:
  - DELTA computation function
  - position-to-width function
  - constant for counter width (32)
- Sub-module servo_pwm_canal, one per channel via generate:
  - holds alvo/atual and the ramp logic
  - produces its pwm bit and em_movimento
- Top level holds the counter, write decode and fim_periodo.

Test Plan (CONF_PERIODO=100, LARGURA_MIN=10, LARGURA_MAX=80, BITS_POS=3 so DELTA=10, N_CANAIS=4, PASSO_RAMPA=0 unless stated):
- Release reset with habilita=4'hF -> each pwm high for 10 cycles per 100-cycle period; fim_periodo pulses every 100 cycles.
- Write ch2 pos=7 mid-period -> ch2 keeps width 10 for the rest of that period, then width 80 from the next period; other channels unchanged.
- PASSO_RAMPA=20, ch0 pos 0->7 -> successive widths 30, 50, 70, 80. em_movimento[0]=1 until the width reaches 80, then 0.
- Write ch1 on the boundary cycle (contagem=99), then wr_canal=9 -> ch1 changes one period later; the write to channel 9 has no effect anywhere.
- Assert reset mid-pulse -> pwm=0 immediately and targets back to 10. With habilita[3]=0, pwm[3] stays 0 while the ramp state keeps advancing.
- SERVO_PWM_DEFASAGEM_EN defined, all channels at pos=0 -> channel k rising edges are 25*k cycles apart.
